// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first multi-cycle add/sub
// BITS_PER_CYCLE slice, start/busy/done handshake
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ov,
  output logic             busy,
  output logic             done
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % BPC) != 0) begin : g_bad_div
    $error("WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             capture;
  logic             last;
  logic [BPC:0]     chunk;
  logic             msb_cin;

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign capture = start && (state != RUN);
  assign last    = (cnt == '0);

  assign chunk = {1'b0, a_sr[BPC-1:0]}
               + {1'b0, b_sr[BPC-1:0]}
               + {{BPC{1'b0}}, carry};

  // carry into the top bit of the slice, recovered from its sum bit
  assign msb_cin = chunk[BPC-1]
                 ^ a_sr[BPC-1]
                 ^ b_sr[BPC-1];

  if (BPC == WIDTH) begin : g_full
    assign s_nxt = chunk[BPC-1:0];
  end else begin : g_part
    assign s_nxt = {chunk[BPC-1:0], S[WIDTH-1:BPC]};
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: start only matters outside RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture and one slice per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      S     <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      Co    <= 1'b0;
      Ov    <= 1'b0;
    end else if (capture) begin
      a_sr  <= A;
      b_sr  <= B ^ {WIDTH{sub}};
      carry <= Ci ^ sub;
      cnt   <= CW'(N - 1);
    end else if (busy) begin
      a_sr  <= a_sr >> BPC;
      b_sr  <= b_sr >> BPC;
      S     <= s_nxt;
      carry <= chunk[BPC];
      cnt   <= cnt - 1'b1;
      if (last) begin
        Co <= chunk[BPC];
        Ov <= chunk[BPC] ^ msb_cin;
      end
    end
  end

endmodule
